pixel_fifo_refill_ctrl: RTL
===========================

// Module: pixel_fifo_refill_ctrl
// PURPOSE
//  Avalon-MM read master and credit-based scheduler that keeps the 8-deep, 36-bit
//  fifo_to_pixel_converter FIFO topped up from a frame buffer in SDRAM. It walks one frame
//  (cfg_base .. cfg_base + cfg_words) in bursts, issuing a burst only when the FIFO is
//  guaranteed to have room. It sits between the SDRAM controller and the FIFO's data_in port.
// PARAMETERS
//  DEPTH       8   FIFO depth in words; must match the FIFO instance
//  LEVEL_W     4   fill_level width (log2(DEPTH)+1)
//  DATA_W      36  word width
//  BURST       4   maximum burst length in words (1..DEPTH)
//  BURST_W     3   m_burstcount width (holds BURST)
//  WORD_BYTES  8   byte address increment per word
// PORTS
//  clk              in   1        clock
//  reset_n          in   1        asynchronous, active-low reset
//  start            in   1        1-cycle pulse; begin a frame (ignored while busy)
//  abort            in   1        1-cycle pulse; stop issuing, drain outstanding reads
//  cfg_base         in   32       frame byte base address, latched on start
//  cfg_words        in   24       words per frame, latched on start
//  busy             out  1        frame or drain in progress
//  frame_done       out  1        1-cycle pulse; all frame words have been written to the FIFO
//  overflow_err     out  1        sticky; readdatavalid seen while fifo_in_ready=0
//  fifo_fill_level  in   LEVEL_W  from FIFO fill_level
//  fifo_in_ready    in   1        from FIFO in_ready
//  fifo_in_valid    out  1        to FIFO in_valid
//  fifo_in_data     out  DATA_W   to FIFO in_data
//  m_address        out  32       Avalon read address
//  m_read           out  1        Avalon read request
//  m_burstcount     out  BURST_W  Avalon burst length
//  m_waitrequest    in   1        Avalon stall
//  m_readdata       in   DATA_W   Avalon read data
//  m_readdatavalid  in   1        Avalon read data strobe
// BEHAVIOUR
//  Reset: state=IDLE. busy, frame_done, overflow_err, m_read, and the remaining and
//  outstanding counters are all 0. m_address=0, m_burstcount=0.
//  Data path: combinational pass-through. fifo_in_valid=m_readdatavalid, fifo_in_data=m_readdata.
//  Credits: outstanding (LEVEL_W bits) = words requested but not yet returned.
//   - Increments by m_burstcount on a request accept (m_read & !m_waitrequest).
//   - Decrements by 1 on each m_readdatavalid.
//   - Both events in the same cycle are applied as a net change.
//  Burst length: blen = min(BURST, remaining).
//  Issue condition: fifo_fill_level + outstanding + blen <= DEPTH, using LEVEL_W+1-bit arithmetic.
//  States:
//   IDLE  : on start, latch cfg into addr/remaining and set busy=1.
//           If cfg_words==0, pulse frame_done next cycle and stay IDLE. Otherwise go to REQ.
//   REQ   : m_read is registered and asserted when the issue condition holds.
//           m_address and m_burstcount are held stable while m_waitrequest=1.
//           On accept: addr += blen*WORD_BYTES and remaining -= blen.
//           When remaining hits 0, go to DRAIN.
//           abort -> go to DRAIN, except a request already stalled is held until accepted.
//   DRAIN : no new requests. When outstanding==0 and no readdatavalid is pending,
//           go to IDLE and clear busy. frame_done pulses only if the frame completed
//           (not aborted), in the same cycle busy falls.
//  Other rules:
//   - start is ignored while busy=1.
//   - abort in IDLE is a no-op.
//   - abort and start in the same IDLE cycle: start wins.
//   - Address wraps modulo 2^32 with no error.
//   - overflow_err is set if m_readdatavalid & !fifo_in_ready; cleared only by reset.
//   - Reset mid-frame clears all state immediately. The SDRAM controller and FIFO
//     share reset_n, so no stale readdata is expected.
// TESTING
//  1. cfg_words=16, base=0x1000, sink always ready
//     -> 4 bursts of 4 at 0x1000/0x1020/0x1040/0x1060; 16 in-order writes; one frame_done.
//  2. cfg_words=10, BURST=4 -> burstcounts 4,4,2; final address 0x1040; frame_done once.
//  3. Sink stalled (FIFO out_ready=0), 20-word frame
//     -> requests stop once fill_level+outstanding reaches 8; fill_level never exceeds 8;
//        overflow_err stays 0.
//  4. m_waitrequest held 5 cycles on the 2nd burst
//     -> address and burstcount stable throughout; no duplicate request.
//  5. abort after the 1st accepted burst of a 32-word frame
//     -> 4 words returned, busy drops after the last readdatavalid, no frame_done.
//  6. cfg_words=0 -> no m_read; frame_done 1 cycle after start.
//     start while busy -> ignored.
//     Async reset mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/pixel_fifo_refill_ctrl.sv
// pixel_fifo_refill_ctrl
// Avalon-MM burst read master that walks one frame buffer and keeps the
// pixel FIFO topped up. A burst is issued only when the FIFO fill level plus
// the words already in flight plus the new burst fits in the FIFO, so read
// data can be passed straight through to the FIFO without back-pressure.
module pixel_fifo_refill_ctrl #(
    parameter int DEPTH      = 8,
    parameter int LEVEL_W    = 4,
    parameter int DATA_W     = 36,
    parameter int BURST      = 4,
    parameter int BURST_W    = 3,
    parameter int WORD_BYTES = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        cfg_base,
    input  logic [23:0]        cfg_words,
    output logic               busy,
    output logic               frame_done,
    output logic               overflow_err,
    input  logic [LEVEL_W-1:0] fifo_fill_level,
    input  logic               fifo_in_ready,
    output logic               fifo_in_valid,
    output logic [DATA_W-1:0]  fifo_in_data,
    output logic [31:0]        m_address,
    output logic               m_read,
    output logic [BURST_W-1:0] m_burstcount,
    input  logic               m_waitrequest,
    input  logic [DATA_W-1:0]  m_readdata,
    input  logic               m_readdatavalid
);

    localparam int LW1 = LEVEL_W + 1;
    typedef logic [LEVEL_W-1:0] cnt_t;
    typedef logic [LW1-1:0]     sum_t;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [23:0]        rem_q, rem_d;
    cnt_t               outst_q, outst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               aborted_q, aborted_d;
    logic               m_read_q, m_read_d;
    logic [31:0]        m_address_q, m_address_d;
    logic [BURST_W-1:0] m_bc_q, m_bc_d;

    logic               accept;
    logic               stalled;
    logic [31:0]        addr_nxt;
    logic [23:0]        rem_nxt;
    logic [BURST_W-1:0] blen;
    sum_t               pend;
    logic               issue_ok;

    // Read data goes straight into the FIFO; credits guarantee it has room.
    assign fifo_in_valid = m_readdatavalid;
    assign fifo_in_data  = m_readdata;

    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign overflow_err  = ovf_q;
    assign m_read        = m_read_q;
    assign m_address     = m_address_q;
    assign m_burstcount  = m_bc_q;

    // Credit bookkeeping and the issue decision for the next burst, evaluated
    // against the state as it will be after this cycle's accept (if any).
    always_comb begin
        accept   = m_read_q & ~m_waitrequest;
        stalled  = m_read_q & m_waitrequest;
        outst_d  = outst_q + (accept ? cnt_t'(m_bc_q) : cnt_t'(0))
                           - (m_readdatavalid ? cnt_t'(1) : cnt_t'(0));
        addr_nxt = accept ? addr_q + 32'(m_bc_q) * 32'(WORD_BYTES) : addr_q;
        rem_nxt  = accept ? rem_q - 24'(m_bc_q) : rem_q;
        blen     = (rem_nxt < 24'(BURST)) ? rem_nxt[BURST_W-1:0] : BURST_W'(BURST);
        // A word returning this cycle is still counted in outst_q and is not
        // yet reflected in the fill level, so the sum never undercounts.
        pend     = sum_t'(outst_q) + (accept ? sum_t'(m_bc_q) : sum_t'(0));
        issue_ok = (sum_t'(fifo_fill_level) + pend + sum_t'(blen)) <= sum_t'(DEPTH);
    end

    // Next-state and registered-output logic for the IDLE/REQ/DRAIN sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_nxt;
        rem_d       = rem_nxt;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        m_read_d    = 1'b0;
        m_address_d = m_address_q;
        m_bc_d      = m_bc_q;
        ovf_d       = ovf_q | (m_readdatavalid & ~fifo_in_ready);

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = cfg_base;
                    rem_d     = cfg_words;
                    aborted_d = 1'b0;
                    if (cfg_words == 24'd0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (stalled) begin
                    // A stalled request must stay on the bus unchanged until taken.
                    m_read_d = 1'b1;
                    if (abort) aborted_d = 1'b1;
                end else if (abort || aborted_q) begin
                    aborted_d = 1'b1;
                    state_d   = DRAIN;
                end else if (rem_nxt == 24'd0) begin
                    state_d = DRAIN;
                end else if (issue_ok) begin
                    m_read_d    = 1'b1;
                    m_address_d = addr_nxt;
                    m_bc_d      = blen;
                end
            end
            DRAIN: begin
                if (outst_q == cnt_t'(0) && !m_readdatavalid) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = ~aborted_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; everything clears on the shared async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            outst_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            aborted_q   <= 1'b0;
            m_read_q    <= 1'b0;
            m_address_q <= '0;
            m_bc_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            outst_q     <= outst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            aborted_q   <= aborted_d;
            m_read_q    <= m_read_d;
            m_address_q <= m_address_d;
            m_bc_q      <= m_bc_d;
        end
    end

endmodule
